// File: rtl/gps_ctrl_pkg.sv
// Shared definitions for the tracking-channel control blocks.
// Provides: FSM state encoding, cfg_sel target codes, counter widths and a
// small saturating helper used when loading phase values.
package gps_ctrl_pkg;

  // Status-register visible state encoding; 2'd3 is never produced.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Configuration write targets.
  localparam logic [1:0] SEL_CHIP = 2'd0;
  localparam logic [1:0] SEL_MS   = 2'd1;
  localparam logic [1:0] SEL_DUMP = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  localparam int CHIP_W = 10;
  localparam int MS_W   = 5;
  localparam int DUMP_W = 8;
  localparam int PEND_W = 10;  // wide enough for any of the three targets

  // Saturate a phase value at the last legal index.
  function automatic logic [PEND_W-1:0] clamp_phase(input logic [PEND_W-1:0] val,
                                                    input logic [PEND_W-1:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter 0..MAX with a load port and a combinational wrap flag.
// Latency: count/load take effect on the next rising edge; o_wrap is same-cycle.
// Backpressure: none; i_load has priority over i_tick (a load replaces the wrap value).
// Ports: i_clk, i_rst_n (async, active-low), i_tick (advance), i_load/i_load_val,
//        o_cnt (current value), o_wrap (i_tick while o_cnt == MAX).
module wrap_counter #(
  parameter int W   = 10,
  parameter int MAX = 1022
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_tick,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MAX);

  logic [W-1:0] r_cnt;

  assign o_wrap = i_tick && (r_cnt == LAST);
  assign o_cnt  = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/epoch_sequencer.sv
// Chip / code-epoch / integration sequencer for one tracking channel, with a
// register-bank write port. Latency: all outputs registered, one edge after cause.
// Backpressure: none; a write arriving while another is pending is dropped (cfg_err).
// Ports: clk, resetn (async, active-low), enable, chip_tick, cfg_wr/cfg_sel/cfg_data,
//        cfg_ack, cfg_err, chip_cnt, ms_plus, ms_over, ms_cnt, dump, state.
module epoch_sequencer
  import gps_ctrl_pkg::*;
#(
  parameter int CODE_LEN   = 1023,
  parameter int MS_PER_BIT = 20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        chip_tick,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_sel,
  input  logic [31:0] cfg_data,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic [9:0]  chip_cnt,
  output logic        ms_plus,
  output logic        ms_over,
  output logic [4:0]  ms_cnt,
  output logic        dump,
  output logic [1:0]  state
);

  localparam logic [PEND_W-1:0] CHIP_MAX = PEND_W'(CODE_LEN - 1);
  localparam logic [PEND_W-1:0] MS_MAX   = PEND_W'(MS_PER_BIT - 1);

  state_e r_state, w_state_nxt;

  logic              r_pend_vld;
  logic [1:0]        r_pend_sel;
  logic [PEND_W-1:0] r_pend_dat;
  logic [DUMP_W-1:0] r_integ;
  logic [DUMP_W-1:0] r_dump_len;
  logic              r_ms_plus, r_ms_over, r_dump, r_ack, r_err;

  logic              w_run, w_direct;
  logic              w_chip_wrap, w_ms_wrap, w_dump_evt;
  logic [PEND_W-1:0] w_wr_val;
  logic              w_dir_chip, w_dir_ms, w_dir_dump, w_dir_ok;
  logic              w_pend_acc, w_pend_chip, w_pend_ms, w_pend_dump, w_pend_apply;
  logic              w_wr_err;
  logic              w_chip_load, w_ms_load;
  logic [CHIP_W-1:0] w_chip_load_val;
  logic [MS_W-1:0]   w_ms_load_val;
  logic [DUMP_W-1:0] w_len_eff;
  logic [DUMP_W:0]   w_integ_inc;
  logic              w_unused_data;

  // Only the low bits of the write word ever matter.
  assign w_unused_data = ^cfg_data[31:PEND_W];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_ARM:  w_state_nxt = !enable ? ST_IDLE : (chip_tick ? ST_RUN : ST_ARM);
      ST_RUN:  w_state_nxt = enable ? ST_RUN : ST_IDLE;
      default: w_state_nxt = enable ? ST_ARM : ST_IDLE;  // IDLE and the unused code
    endcase
  end

  assign w_run = (r_state == ST_RUN);
  // Writes apply immediately unless the channel is actively running; while
  // enable is low the pending slot is being flushed, so act as if idle.
  assign w_direct = !w_run || !enable;

  // ---------------- write decode ----------------
  always_comb begin
    w_wr_val = '0;
    case (cfg_sel)
      SEL_CHIP: w_wr_val = clamp_phase(cfg_data[PEND_W-1:0], CHIP_MAX);
      SEL_MS:   w_wr_val = clamp_phase({{(PEND_W-MS_W){1'b0}}, cfg_data[MS_W-1:0]}, MS_MAX);
      SEL_DUMP: w_wr_val = {{(PEND_W-DUMP_W){1'b0}}, cfg_data[DUMP_W-1:0]};
      default:  w_wr_val = '0;
    endcase
  end

  assign w_dir_ok   = cfg_wr && w_direct && (cfg_sel != SEL_RSVD);
  assign w_dir_chip = w_dir_ok && (cfg_sel == SEL_CHIP);
  assign w_dir_ms   = w_dir_ok && (cfg_sel == SEL_MS);
  assign w_dir_dump = w_dir_ok && (cfg_sel == SEL_DUMP);

  assign w_pend_acc = cfg_wr && !w_direct && (cfg_sel != SEL_RSVD) && !r_pend_vld;
  assign w_wr_err   = cfg_wr && ((cfg_sel == SEL_RSVD) || (!w_direct && r_pend_vld));

  // Pending phase writes land on the epoch wrap, dump length on the dump edge.
  assign w_pend_chip  = r_pend_vld && enable && (r_pend_sel == SEL_CHIP) && w_chip_wrap;
  assign w_pend_ms    = r_pend_vld && enable && (r_pend_sel == SEL_MS)   && w_chip_wrap;
  assign w_pend_dump  = r_pend_vld && enable && (r_pend_sel == SEL_DUMP) && w_dump_evt;
  assign w_pend_apply = w_pend_chip || w_pend_ms || w_pend_dump;

  // ---------------- counters ----------------
  assign w_chip_load     = w_dir_chip || w_pend_chip;
  assign w_chip_load_val = w_dir_chip ? w_wr_val[CHIP_W-1:0] : r_pend_dat[CHIP_W-1:0];
  assign w_ms_load       = w_dir_ms || w_pend_ms;
  assign w_ms_load_val   = w_dir_ms ? w_wr_val[MS_W-1:0] : r_pend_dat[MS_W-1:0];

  wrap_counter #(.W(CHIP_W), .MAX(CODE_LEN - 1)) u_chip (
    .i_clk      (clk),
    .i_rst_n    (resetn),
    .i_tick     (w_run && chip_tick),
    .i_load     (w_chip_load),
    .i_load_val (w_chip_load_val),
    .o_cnt      (chip_cnt),
    .o_wrap     (w_chip_wrap)
  );

  wrap_counter #(.W(MS_W), .MAX(MS_PER_BIT - 1)) u_ms (
    .i_clk      (clk),
    .i_rst_n    (resetn),
    .i_tick     (w_chip_wrap),
    .i_load     (w_ms_load),
    .i_load_val (w_ms_load_val),
    .o_cnt      (ms_cnt),
    .o_wrap     (w_ms_wrap)
  );

  // Zero length behaves as one; >= keeps a shortened length from being skipped.
  assign w_len_eff   = (r_dump_len == '0) ? DUMP_W'(1) : r_dump_len;
  assign w_integ_inc = {1'b0, r_integ} + 1'b1;
  assign w_dump_evt  = w_chip_wrap && (w_integ_inc >= {1'b0, w_len_eff});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_integ    <= '0;
      r_dump_len <= DUMP_W'(1);
    end else begin
      if (w_chip_wrap) r_integ <= w_dump_evt ? '0 : w_integ_inc[DUMP_W-1:0];
      if (w_dir_dump)       r_dump_len <= w_wr_val[DUMP_W-1:0];
      else if (w_pend_dump) r_dump_len <= r_pend_dat[DUMP_W-1:0];
    end
  end

  // ---------------- pending write slot ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_vld <= 1'b0;
      r_pend_sel <= SEL_CHIP;
      r_pend_dat <= '0;
    end else if (!enable || w_pend_apply) begin
      r_pend_vld <= 1'b0;
    end else if (w_pend_acc) begin
      r_pend_vld <= 1'b1;
      r_pend_sel <= cfg_sel;
      r_pend_dat <= w_wr_val;
    end
  end

  // ---------------- registered pulses ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_plus <= 1'b0;
      r_ms_over <= 1'b0;
      r_dump    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ms_plus <= w_chip_wrap;
      r_ms_over <= w_ms_wrap;
      r_dump    <= w_dump_evt;
      r_ack     <= w_dir_ok || w_pend_apply;
      r_err     <= w_wr_err;
    end
  end

  assign ms_plus = r_ms_plus;
  assign ms_over = r_ms_over;
  assign dump    = r_dump;
  assign cfg_ack = r_ack;
  assign cfg_err = r_err;
  assign state   = r_state;

endmodule

// File: tb/tb_epoch_sequencer.sv
// Bench for epoch_sequencer: directed scenarios plus a randomized stretch, all
// checked every cycle against a behavioural model of the sequencing rules.
module tb_epoch_sequencer;

  localparam int CL  = 1023;
  localparam int MPB = 20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        chip_tick = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [31:0] cfg_data = 32'd0;
  logic        cfg_ack, cfg_err, ms_plus, ms_over, dump;
  logic [9:0]  chip_cnt;
  logic [4:0]  ms_cnt;
  logic [1:0]  state;

  epoch_sequencer #(.CODE_LEN(CL), .MS_PER_BIT(MPB)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .chip_tick(chip_tick),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .chip_cnt(chip_cnt),
    .ms_plus(ms_plus), .ms_over(ms_over), .ms_cnt(ms_cnt),
    .dump(dump), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 0 idle, 1 armed, 2 running.
  int m_state, m_chip, m_ms, m_integ, m_len, m_psel, m_pval;
  bit m_pend;
  bit e_plus, e_over, e_dump, e_ack, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input logic [1:0] s, input logic [31:0] d);
    int v;
    v = 0;
    case (s)
      2'd0: begin v = int'(d % 32'd1024); if (v > CL - 1) v = CL - 1; end
      2'd1: begin v = int'(d % 32'd32);   if (v > MPB - 1) v = MPB - 1; end
      2'd2: v = int'(d % 32'd256);
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic m_reset();
    m_state = 0; m_chip = 0; m_ms = 0; m_integ = 0; m_len = 1;
    m_pend = 0; m_psel = 0; m_pval = 0;
    e_plus = 0; e_over = 0; e_dump = 0; e_ack = 0; e_err = 0;
  endtask

  // One clock edge of the sequencing rules, using the inputs present at the edge.
  task automatic model_edge();
    bit pend0, direct, go;
    int v;
    e_plus = 0; e_over = 0; e_dump = 0; e_ack = 0; e_err = 0;
    pend0  = m_pend;
    go     = pend0 && (enable == 1'b1);
    direct = (m_state != 2) || !enable;
    v      = clampv(cfg_sel, cfg_data);
    if (m_state == 2 && chip_tick) begin
      if (m_chip == CL - 1) begin
        e_plus = 1;
        e_over = (m_ms == MPB - 1);
        m_chip = (go && m_psel == 0) ? m_pval : 0;
        m_ms   = (go && m_psel == 1) ? m_pval : (m_ms + 1) % MPB;
        if (go && m_psel != 2) begin e_ack = 1; m_pend = 0; end
        m_integ++;
        if (m_integ >= ((m_len == 0) ? 1 : m_len)) begin
          m_integ = 0;
          e_dump  = 1;
          if (go && m_psel == 2) begin m_len = m_pval; e_ack = 1; m_pend = 0; end
        end
      end else begin
        m_chip++;
      end
    end
    if (cfg_wr) begin
      if (cfg_sel == 2'd3) e_err = 1;
      else if (direct) begin
        if (cfg_sel == 2'd0) m_chip = v;
        else if (cfg_sel == 2'd1) m_ms = v;
        else m_len = v;
        e_ack = 1;
      end else if (pend0) e_err = 1;
      else begin m_pend = 1; m_psel = int'(cfg_sel); m_pval = v; end
    end
    if (!enable) m_pend = 0;
    case (m_state)
      0: m_state = enable ? 1 : 0;
      1: m_state = !enable ? 0 : (chip_tick ? 2 : 1);
      default: m_state = enable ? 2 : 0;
    endcase
  endtask

  task automatic check_all();
    chk("state",    state,    m_state);
    chk("chip_cnt", chip_cnt, m_chip);
    chk("ms_cnt",   ms_cnt,   m_ms);
    chk("ms_plus",  ms_plus,  e_plus);
    chk("ms_over",  ms_over,  e_over);
    chk("dump",     dump,     e_dump);
    chk("cfg_ack",  cfg_ack,  e_ack);
    chk("cfg_err",  cfg_err,  e_err);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"},   state,    0);
    chk({tag, "_chip"},    chip_cnt, 0);
    chk({tag, "_ms"},      ms_cnt,   0);
    chk({tag, "_plus"},    ms_plus,  0);
    chk({tag, "_over"},    ms_over,  0);
    chk({tag, "_dump"},    dump,     0);
    chk({tag, "_ack"},     cfg_ack,  0);
    chk({tag, "_err"},     cfg_err,  0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit t);
    chip_tick = t;
    step();
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d, input bit t);
    cfg_wr = 1'b1; cfg_sel = s; cfg_data = d; chip_tick = t;
    step();
    cfg_wr = 1'b0;
  endtask

  initial begin
    int n_p, n_o, n_d, n_a;
    bit found;
    m_reset();

    // Reset values, then release between edges.
    #12;
    check_reset("rst");
    #10 resetn = 1'b1;   // t=22, clock edges at 25, 35, ...
    cyc(0);              // no pulses in first cycle after release

    // Arm, enter RUN on the first tick (not counted), then one full epoch.
    enable = 1'b1;
    cyc(0);
    cyc(1);
    n_p = 0;
    for (int i = 0; i < CL; i++) begin
      cyc(1);
      n_p += int'(ms_plus);
    end
    chk("epoch1_plus_count", n_p, 1);
    chk("epoch1_plus_last",  ms_plus, 1);
    chk("epoch1_chip_wrap",  chip_cnt, 0);

    // Epochs 2..20: ms_over only on the 20th ms_plus.
    n_p = 0; n_o = 0;
    for (int i = 0; i < 19 * CL; i++) begin
      cyc(1);
      n_p += int'(ms_plus);
      n_o += int'(ms_over);
    end
    chk("bit_plus_count", n_p, 19);
    chk("bit_over_count", n_o, 1);
    chk("bit_over_last",  ms_over, 1);
    chk("bit_ms_wrap",    ms_cnt, 0);

    // Dump length 5 in RUN: ack on the next dump, then dump every 5th epoch.
    wr(2'd2, 32'd5, 1'b1);
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if (cfg_ack) begin found = 1; break; end
    end
    chk("dlen_ack_seen",  found, 1);
    chk("dlen_ack_dump",  dump, 1);
    n_p = 0; n_d = 0;
    for (int i = 0; i < 12000 && n_p < 10; i++) begin
      cyc(1);
      n_p += int'(ms_plus);
      n_d += int'(dump);
    end
    chk("dlen_plus_count", n_p, 10);
    chk("dlen_dump_count", n_d, 2);
    chk("dlen_dump_10th",  dump, 1);

    // Chip-phase 500 pending, second write dropped, applied at next wrap.
    wr(2'd0, 32'd500, 1'b1);
    chk("phase_no_early_ack", cfg_ack, 0);
    wr(2'd0, 32'd77, 1'b1);
    chk("phase_second_err", cfg_err, 1);
    found = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc(1);
      if (ms_plus) begin found = 1; break; end
    end
    chk("phase_wrap_seen", found, 1);
    chk("phase_chip_500",  chip_cnt, 500);
    chk("phase_ack",       cfg_ack, 1);

    // Randomized traffic: sparse ticks, writes of every kind, enable drops.
    for (int i = 0; i < 15000; i++) begin
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      chip_tick = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) begin
        cfg_wr  = 1'b1;
        cfg_sel = 2'($urandom_range(0, 3));
        case (cfg_sel)
          2'd0: cfg_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
          2'd1: cfg_data = 32'($urandom_range(0, 40));
          2'd2: cfg_data = 32'($urandom_range(0, 6));
          default: cfg_data = $urandom;
        endcase
      end else begin
        cfg_wr = 1'b0;
      end
      step();
    end
    cfg_wr = 1'b0;

    // Dump length 0 written while idle: dump on every epoch.
    enable = 1'b0;
    cyc(0);
    cyc(0);
    wr(2'd2, 32'd0, 1'b0);
    chk("len0_idle_ack", cfg_ack, 1);
    wr(2'd0, 32'd1000, 1'b0);
    chk("idle_chip_load", chip_cnt, 1000);
    enable = 1'b1;
    cyc(0);
    cyc(1);
    n_p = 0; n_d = 0;
    for (int i = 0; i < 2500 && n_p < 2; i++) begin
      cyc(1);
      n_p += int'(ms_plus);
      n_d += int'(dump);
    end
    chk("len0_plus_count", n_p, 2);
    chk("len0_dump_count", n_d, 2);

    // Asynchronous reset mid-RUN with a write pending.
    wr(2'd0, 32'd300, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1);
    #2 resetn = 1'b0;
    #1 check_reset("arst");
    m_reset();
    #2 resetn = 1'b1;
    n_a = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc(1);
      n_a += int'(cfg_ack);
    end
    chk("arst_no_ack", n_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
